// File: rtl/task_executor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : task_executor_if                                              |
// | Purpose  : Bus between the hardware scheduler and the task executor.     |
// |            Carries the tick, both per-core slot buses, the publish       |
// |            strobe and the completion/miss/status reports.                |
// | Modports : master - scheduler side (drives tick, running_tasks_out)      |
// |            slave  - executor side (drives everything else)               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface task_executor_if #(
  parameter int W    = 42,
  parameter int CORE = 16,
  parameter int IDXW = 4
);
  logic                tick;
  logic [W*CORE-1:0]   running_tasks_out;
  logic [W*CORE-1:0]   running_tasks_in;
  logic                CTRL_subtract;
  logic                busy;
  logic                done_v;
  logic [7:0]          done_id;
  logic [IDXW-1:0]     done_core;
  logic                miss_v;
  logic [7:0]          miss_id;
  logic                overrun;

  modport master (
    output tick, running_tasks_out,
    input  running_tasks_in, CTRL_subtract, busy, done_v, done_id,
           done_core, miss_v, miss_id, overrun
  );

  modport slave (
    input  tick, running_tasks_out,
    output running_tasks_in, CTRL_subtract, busy, done_v, done_id,
           done_core, miss_v, miss_id, overrun
  );
endinterface
`default_nettype wire

// File: rtl/task_executor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : task_executor                                                 |
// | Purpose  : Core-side model of the processors fed by the scheduler. On    |
// |            each tick it snapshots the dispatched slots, walks them one   |
// |            per cycle (aging exec/deadline, retiring finished tasks,      |
// |            flagging deadline misses) and publishes the aged bus back     |
// |            with a one-cycle CTRL_subtract strobe.                        |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            bus (slave)     - tick/slot buses/strobe/reports              |
// |            stat_done/miss  - saturating event counters (optional)        |
// | Options  : EXEC_STATS_EN   - adds the stat_done/stat_miss counters       |
// | Slot     : [W-1] running, [40] critical, [39:32] ID,                     |
// |            [31:16] relative deadline, [15:0] execution time              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module task_executor #(
  parameter int W    = 42,
  parameter int CORE = 16,
  parameter int IDXW = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  task_executor_if.slave   bus
`ifdef EXEC_STATS_EN
  ,
  output logic [31:0]      stat_done,
  output logic [31:0]      stat_miss
`endif
);

  localparam int              c_id_lsb   = 32;
  localparam logic [IDXW-1:0] c_idx_last = IDXW'(CORE - 1);
  localparam logic [IDXW-1:0] c_idx_one  = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SWEEP   = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDXW-1:0]     r_idx;
  logic [W*CORE-1:0]   r_shadow;
  logic [W*CORE-1:0]   r_tasks_in;
  logic                r_subtract;
  logic                r_busy;
  logic                r_done_v;
  logic [7:0]          r_done_id;
  logic [IDXW-1:0]     r_done_core;
  logic                r_miss_v;
  logic [7:0]          r_miss_id;
  logic                r_overrun;
`ifdef EXEC_STATS_EN
  logic [31:0]         r_stat_done;
  logic [31:0]         r_stat_miss;
`endif

  logic [31:0]         w_base;
  logic [W-1:0]        w_slot;
  logic [W-1:0]        w_new_slot;
  logic [15:0]         w_exec;
  logic [15:0]         w_dl;
  logic                w_done;
  logic                w_miss;
  logic [W*CORE-1:0]   w_shadow_upd;

  assign w_base = 32'(r_idx) * 32'(W);
  assign w_slot = r_shadow[w_base +: W];
  assign w_exec = w_slot[15:0];
  assign w_dl   = w_slot[31:16];

  // Aging of the slot currently under the sweep pointer. Both counters
  // saturate at zero; a miss is only the 1->0 deadline transition so it
  // cannot re-fire, and completion masks a simultaneous miss.
  always_comb begin
    w_new_slot = w_slot;
    w_done     = 1'b0;
    w_miss     = 1'b0;
    if (w_slot[W-1]) begin
      if (w_exec == 16'd0) begin
        w_new_slot[W-1] = 1'b0;
        w_done          = 1'b1;
      end else begin
        w_new_slot[15:0] = w_exec - 16'd1;
        if (w_dl != 16'd0) begin
          w_new_slot[31:16] = w_dl - 16'd1;
        end
        if (w_exec == 16'd1) begin
          w_new_slot[W-1] = 1'b0;
          w_done          = 1'b1;
        end else if (w_dl == 16'd1) begin
          w_miss = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_shadow_upd               = r_shadow;
    w_shadow_upd[w_base +: W]  = w_new_slot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_tasks_in  <= '0;
      r_subtract  <= 1'b0;
      r_busy      <= 1'b0;
      r_done_v    <= 1'b0;
      r_done_id   <= '0;
      r_done_core <= '0;
      r_miss_v    <= 1'b0;
      r_miss_id   <= '0;
      r_overrun   <= 1'b0;
`ifdef EXEC_STATS_EN
      r_stat_done <= '0;
      r_stat_miss <= '0;
`endif
    end else begin
      r_done_v   <= 1'b0;
      r_miss_v   <= 1'b0;
      r_subtract <= 1'b0;

      // Any tick that cannot start a sweep is lost; remember that it happened.
      if (bus.tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.tick) begin
            r_shadow <= bus.running_tasks_out;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SWEEP;
          end
        end

        S_SWEEP: begin
          r_shadow <= w_shadow_upd;
          r_done_v <= w_done;
          r_miss_v <= w_miss;
          if (w_done) begin
            r_done_id   <= w_slot[c_id_lsb +: 8];
            r_done_core <= r_idx;
          end
          if (w_miss) begin
            r_miss_id <= w_slot[c_id_lsb +: 8];
          end
`ifdef EXEC_STATS_EN
          if (w_done && (r_stat_done != 32'hFFFF_FFFF)) begin
            r_stat_done <= r_stat_done + 32'd1;
          end
          if (w_miss && (r_stat_miss != 32'hFFFF_FFFF)) begin
            r_stat_miss <= r_stat_miss + 32'd1;
          end
`endif
          if (r_idx == c_idx_last) begin
            // Publish the fully aged snapshot, including the last slot.
            r_tasks_in <= w_shadow_upd;
            r_subtract <= 1'b1;
            r_state    <= S_PUBLISH;
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end

        S_PUBLISH: begin
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.running_tasks_in = r_tasks_in;
  assign bus.CTRL_subtract    = r_subtract;
  assign bus.busy             = r_busy;
  assign bus.done_v           = r_done_v;
  assign bus.done_id          = r_done_id;
  assign bus.done_core        = r_done_core;
  assign bus.miss_v           = r_miss_v;
  assign bus.miss_id          = r_miss_id;
  assign bus.overrun          = r_overrun;
`ifdef EXEC_STATS_EN
  assign stat_done            = r_stat_done;
  assign stat_miss            = r_stat_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_task_executor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_task_executor                                              |
// | Purpose  : Directed self-checking bench for task_executor, CORE=4.       |
// |            Each scenario task drives ticks and slot contents and checks  |
// |            hand-computed results per cycle.                              |
// | Options  : EXEC_STATS_EN   - also exercises the event counters           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_task_executor;

  localparam int c_w    = 42;
  localparam int c_core = 4;
  localparam int c_idxw = 4;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  // Per-cycle records of one sweep; bit/entry j = j-th cycle after the tick edge.
  logic [5:0] rec_done_m;
  logic [5:0] rec_miss_m;
  logic [5:0] rec_ctrl_m;
  logic [5:0] rec_busy_m;
  logic [7:0] rec_did   [0:5];
  logic [3:0] rec_dcore [0:5];
  logic [7:0] rec_mid   [0:5];

  task_executor_if #(.W(c_w), .CORE(c_core), .IDXW(c_idxw)) bus ();

`ifdef EXEC_STATS_EN
  logic [31:0] stat_done;
  logic [31:0] stat_miss;
`endif

  task_executor #(.W(c_w), .CORE(c_core), .IDXW(c_idxw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef EXEC_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_miss (stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [41:0] mk(input logic run, input logic crit,
                                     input logic [7:0] id, input logic [15:0] dl,
                                     input logic [15:0] ex);
    return {run, crit, id, dl, ex};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int j);
    rec_done_m[j] = bus.done_v;
    rec_miss_m[j] = bus.miss_v;
    rec_ctrl_m[j] = bus.CTRL_subtract;
    rec_busy_m[j] = bus.busy;
    rec_did[j]    = bus.done_id;
    rec_dcore[j]  = bus.done_core;
    rec_mid[j]    = bus.miss_id;
  endtask

  // One tick followed by a full sweep; ends in the first IDLE cycle.
  task automatic run_sweep(input logic [167:0] slots);
    bus.running_tasks_out = slots;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    capture(0);
    for (int j = 1; j <= 5; j++) begin
      step();
      capture(j);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.running_tasks_in !== 168'd0) begin n_bad++; $display("FAIL reset_tin got %h want 0", bus.running_tasks_in); end
    n_cmp++; if (bus.CTRL_subtract !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0", bus.CTRL_subtract); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if ({bus.done_v, bus.miss_v, bus.overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {bus.done_v, bus.miss_v, bus.overrun}); end
    n_cmp++; if ({bus.done_id, bus.done_core, bus.miss_id} !== 20'd0) begin n_bad++; $display("FAIL reset_ids got %h want 0", {bus.done_id, bus.done_core, bus.miss_id}); end
  endtask

  task automatic test_aging();
    logic [167:0] v;
    logic [41:0]  s3;
    s3 = mk(1'b0, 1'b1, 8'hAA, 16'h1234, 16'h0007);
    v = '0;
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd10, 16'd3);
    v[126 +: 42] = s3;
    run_sweep(v);
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd9, 16'd2);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL aging_t1 got %h want %h", bus.running_tasks_in, v); end
    n_cmp++; if (rec_ctrl_m !== 6'b010000) begin n_bad++; $display("FAIL aging_ctrl got %b want 010000", rec_ctrl_m); end
    n_cmp++; if (rec_busy_m !== 6'b011111) begin n_bad++; $display("FAIL aging_busy got %b want 011111", rec_busy_m); end
    n_cmp++; if ((rec_done_m | rec_miss_m) !== 6'b000000) begin n_bad++; $display("FAIL aging_t1_pulses got %b want 000000", rec_done_m | rec_miss_m); end
    run_sweep(v);
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd8, 16'd1);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL aging_t2 got %h want %h", bus.running_tasks_in, v); end
    run_sweep(v);
    v[0 +: 42] = mk(1'b0, 1'b0, 8'h05, 16'd7, 16'd0);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL aging_t3 got %h want %h", bus.running_tasks_in, v); end
    n_cmp++; if (rec_done_m !== 6'b000010) begin n_bad++; $display("FAIL aging_done got %b want 000010", rec_done_m); end
    n_cmp++; if ({rec_did[1], rec_dcore[1]} !== {8'h05, 4'd0}) begin n_bad++; $display("FAIL aging_done_id got %h/%0d want 05/0", rec_did[1], rec_dcore[1]); end
    n_cmp++; if (rec_miss_m !== 6'b000000) begin n_bad++; $display("FAIL aging_miss got %b want 000000", rec_miss_m); end
  endtask

  task automatic test_miss();
    logic [167:0] v;
    v = '0;
    v[84 +: 42] = mk(1'b1, 1'b0, 8'h11, 16'd1, 16'd5);
    run_sweep(v);
    v[84 +: 42] = mk(1'b1, 1'b0, 8'h11, 16'd0, 16'd4);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL miss_t1 got %h want %h", bus.running_tasks_in, v); end
    n_cmp++; if (rec_miss_m !== 6'b001000) begin n_bad++; $display("FAIL miss_pulse got %b want 001000", rec_miss_m); end
    n_cmp++; if (rec_mid[3] !== 8'h11) begin n_bad++; $display("FAIL miss_id got %h want 11", rec_mid[3]); end
    n_cmp++; if (rec_done_m !== 6'b000000) begin n_bad++; $display("FAIL miss_nodone got %b want 000000", rec_done_m); end
    run_sweep(v);
    v[84 +: 42] = mk(1'b1, 1'b0, 8'h11, 16'd0, 16'd3);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL miss_t2 got %h want %h", bus.running_tasks_in, v); end
    n_cmp++; if (rec_miss_m !== 6'b000000) begin n_bad++; $display("FAIL miss_refire got %b want 000000", rec_miss_m); end
  endtask

  task automatic test_done_priority();
    logic [167:0] v;
    v = '0;
    v[42 +: 42]  = mk(1'b1, 1'b0, 8'h22, 16'd1, 16'd1);
    v[126 +: 42] = mk(1'b1, 1'b1, 8'h33, 16'd4, 16'd0);
    run_sweep(v);
    v[42 +: 42]  = mk(1'b0, 1'b0, 8'h22, 16'd0, 16'd0);
    v[126 +: 42] = mk(1'b0, 1'b1, 8'h33, 16'd4, 16'd0);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL prio_tin got %h want %h", bus.running_tasks_in, v); end
    n_cmp++; if (rec_done_m !== 6'b010100) begin n_bad++; $display("FAIL prio_done got %b want 010100", rec_done_m); end
    n_cmp++; if (rec_miss_m !== 6'b000000) begin n_bad++; $display("FAIL prio_miss got %b want 000000", rec_miss_m); end
    n_cmp++; if ({rec_did[2], rec_dcore[2]} !== {8'h22, 4'd1}) begin n_bad++; $display("FAIL prio_id1 got %h/%0d want 22/1", rec_did[2], rec_dcore[2]); end
    n_cmp++; if ({rec_did[4], rec_dcore[4]} !== {8'h33, 4'd3}) begin n_bad++; $display("FAIL prio_id3 got %h/%0d want 33/3", rec_did[4], rec_dcore[4]); end
  endtask

  task automatic test_overrun();
    logic [8:0] ctrl_m;
    logic [8:0] busy_m;
    logic       ovr_early;
    ctrl_m = '0;
    busy_m = '0;
    bus.running_tasks_out = '0;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) bus.tick = 1'b1;
      if (c == 1) ovr_early = bus.overrun;
      ctrl_m[c] = bus.CTRL_subtract;
      busy_m[c] = bus.busy;
      step();
      bus.tick = 1'b0;
    end
    n_cmp++; if (ovr_early !== 1'b0) begin n_bad++; $display("FAIL ovr_before got %b want 0", ovr_early); end
    n_cmp++; if (ctrl_m !== 9'b000100000) begin n_bad++; $display("FAIL ovr_ctrl got %b want 000100000", ctrl_m); end
    n_cmp++; if (busy_m !== 9'b000111110) begin n_bad++; $display("FAIL ovr_busy got %b want 000111110", busy_m); end
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
  endtask

  task automatic test_rst_mid();
    logic [167:0] v;
    logic [4:0]   ctrl_m;
    v = '0;
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd10, 16'd3);
    bus.running_tasks_out = v;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.running_tasks_in !== 168'd0) begin n_bad++; $display("FAIL rstmid_tin got %h want 0", bus.running_tasks_in); end
    n_cmp++; if ({bus.CTRL_subtract, bus.busy, bus.done_v, bus.miss_v, bus.overrun} !== 5'b00000) begin n_bad++; $display("FAIL rstmid_flags got %b want 00000", {bus.CTRL_subtract, bus.busy, bus.done_v, bus.miss_v, bus.overrun}); end
    n_cmp++; if ({bus.done_id, bus.done_core, bus.miss_id} !== 20'd0) begin n_bad++; $display("FAIL rstmid_ids got %h want 0", {bus.done_id, bus.done_core, bus.miss_id}); end
    ctrl_m = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      ctrl_m[c] = bus.CTRL_subtract | bus.busy;
    end
    n_cmp++; if (ctrl_m !== 5'b00000) begin n_bad++; $display("FAIL rstmid_quiet got %b want 00000", ctrl_m); end
    run_sweep(v);
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd9, 16'd2);
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL rstmid_resweep got %h want %h", bus.running_tasks_in, v); end
    n_cmp++; if (rec_ctrl_m !== 6'b010000) begin n_bad++; $display("FAIL rstmid_ctrl got %b want 010000", rec_ctrl_m); end
  endtask

  task automatic test_back_to_back();
    logic [167:0] v;
    v = '0;
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd9, 16'd2);
    bus.running_tasks_out = v;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    for (int c = 0; c < 4; c++) step();
    v[0 +: 42] = mk(1'b1, 1'b0, 8'h05, 16'd8, 16'd1);
    n_cmp++; if (bus.CTRL_subtract !== 1'b1) begin n_bad++; $display("FAIL b2b_ctrl1 got %b want 1", bus.CTRL_subtract); end
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL b2b_tin1 got %h want %h", bus.running_tasks_in, v); end
    // Tick during PUBLISH is dropped; holding it one more cycle lands in IDLE.
    bus.running_tasks_out = v;
    bus.tick = 1'b1;
    step();
    n_cmp++; if ({bus.busy, bus.overrun} !== 2'b01) begin n_bad++; $display("FAIL b2b_drop got busy/ovr %b want 01", {bus.busy, bus.overrun}); end
    step();
    bus.tick = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
    for (int c = 0; c < 4; c++) step();
    v[0 +: 42] = mk(1'b0, 1'b0, 8'h05, 16'd7, 16'd0);
    n_cmp++; if (bus.CTRL_subtract !== 1'b1) begin n_bad++; $display("FAIL b2b_ctrl2 got %b want 1", bus.CTRL_subtract); end
    n_cmp++; if (bus.running_tasks_in !== v) begin n_bad++; $display("FAIL b2b_tin2 got %h want %h", bus.running_tasks_in, v); end
    step();
  endtask

`ifdef EXEC_STATS_EN
  task automatic test_stats();
    logic [167:0] v;
    rst = 1'b1;
    step();
    rst = 1'b0;
    v = '0;
    v[0 +: 42]   = mk(1'b1, 1'b0, 8'h01, 16'd5, 16'd1);
    v[42 +: 42]  = mk(1'b1, 1'b0, 8'h02, 16'd5, 16'd0);
    v[84 +: 42]  = mk(1'b1, 1'b0, 8'h03, 16'd3, 16'd1);
    v[126 +: 42] = mk(1'b1, 1'b0, 8'h04, 16'd1, 16'd9);
    run_sweep(v);
    n_cmp++; if (stat_done !== 32'd3) begin n_bad++; $display("FAIL stat_done got %0d want 3", stat_done); end
    n_cmp++; if (stat_miss !== 32'd1) begin n_bad++; $display("FAIL stat_miss got %0d want 1", stat_miss); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({stat_done, stat_miss} !== 64'd0) begin n_bad++; $display("FAIL stat_reset got %0d/%0d want 0/0", stat_done, stat_miss); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.running_tasks_out = '0;
    rec_done_m = '0;
    rec_miss_m = '0;
    rec_ctrl_m = '0;
    rec_busy_m = '0;
    test_reset();
    test_aging();
    test_miss();
    test_done_priority();
    n_cmp++; if ((rec_done_m & rec_miss_m) !== 6'b000000) begin n_bad++; $display("FAIL done_miss_overlap got %b want 000000", rec_done_m & rec_miss_m); end
    test_overrun();
    test_rst_mid();
    test_back_to_back();
`ifdef EXEC_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
